fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 109 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: grants one requester at a time a burst of up to
// MAX_BURST beats into a shared FIFO write port, with packet-boundary release.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no grant; arbitrating among valid requesters, no transfers
// S_BURST | grant_id owns the FIFO port until last beat or MAX_BURST
module fifo_wr_arbiter #(
    parameter int NREQ       = 4,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_BURST  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NREQ-1:0]              req_valid,
    input  logic [NREQ*DATA_WIDTH-1:0]   req_data,
    input  logic [NREQ-1:0]              req_last,
    output logic [NREQ-1:0]              req_ready,
    output logic [DATA_WIDTH-1:0]        fifo_wr_data,
    output logic                         fifo_wr_en,
    input  logic                         fifo_full,
    output logic [$clog2(NREQ)-1:0]      grant_id,
    output logic                         busy
);

    localparam int GW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    logic [0:0]    state;
    logic [GW-1:0] grant_q;
    logic [GW-1:0] rr_ptr;
    logic [CW-1:0] beat_cnt;

    logic          pick_found;
    logic [GW-1:0] pick_idx;
    logic [GW-1:0] cand;
    logic          in_burst;
    logic          xfer;
    logic [CW-1:0] beat_cnt_inc;
    logic          burst_done;
    logic [GW-1:0] next_ptr;

    // Scan from rr_ptr upward with wrap; iterating downward lets the
    // candidate closest to the pointer overwrite the others.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = GW'((int'(rr_ptr) + k) % NREQ);
            if (req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Reset is folded into the outputs so nothing moves in the reset cycle.
    assign in_burst     = (state == S_BURST) && !rst;
    assign xfer         = in_burst && req_valid[grant_q] && !fifo_full;
    assign beat_cnt_inc = beat_cnt + CW'(1);
    assign burst_done   = req_last[grant_q] || (beat_cnt_inc == CW'(MAX_BURST));
    assign next_ptr     = (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + 1'b1;

    always_comb begin
        req_ready = '0;
        if (in_burst && !fifo_full) begin
            req_ready[grant_q] = 1'b1;
        end
    end

    assign fifo_wr_en   = xfer;
    assign fifo_wr_data = req_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
    assign busy         = in_burst;
    assign grant_id     = rst ? '0 : grant_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            rr_ptr   <= '0;
            grant_q  <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        grant_q  <= pick_idx;
                        beat_cnt <= '0;
                        state    <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (xfer) begin
                        beat_cnt <= beat_cnt_inc;
                        if (burst_done) begin
                            state  <= S_IDLE;
                            rr_ptr <= next_ptr;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed packets per requester, expected
// FIFO writes queued up front and checked by a negedge monitor.
module tb_fifo_wr_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 16;
    localparam int MB   = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*DW-1:0] req_data = '0;
    logic [NREQ-1:0]   req_last = '0;
    logic [NREQ-1:0]   req_ready;
    logic [DW-1:0]     fifo_wr_data;
    logic              fifo_wr_en;
    logic              fifo_full = 1'b0;
    logic [1:0]        grant_id;
    logic              busy;

    fifo_wr_arbiter #(.NREQ(NREQ), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready),
        .fifo_wr_data(fifo_wr_data), .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    logic [16:0]     rq [NREQ][$];
    logic [NREQ-1:0] hold = '0;
    logic [NREQ-1:0] acc = '0;
    int              sb [$];
    int              log_cyc [$];
    int              log_gid [$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic add_beat(input int r, input int data, input bit last);
        logic [15:0] d;
        d = data[15:0];
        rq[r].push_back({last, d});
    endtask

    task automatic exp_push(input int gid, input int data);
        sb.push_back((gid << 16) | (data & 'hFFFF));
    endtask

    always @(posedge clk) cyc++;

    // Requester models: pop accepted beats, then present the next one.
    always @(posedge clk) begin
        logic [16:0] tmp;
        #2;
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i] && rq[i].size() > 0) tmp = rq[i].pop_front();
            if (rq[i].size() > 0 && !hold[i]) begin
                req_valid[i] = 1'b1;
                req_data[i*DW +: DW] = rq[i][0][15:0];
                req_last[i] = rq[i][0][16];
            end else begin
                req_valid[i] = 1'b0;
                req_last[i] = 1'b0;
            end
        end
    end

    // Monitor: every FIFO write is matched against the next expected entry.
    always @(negedge clk) begin
        int e;
        acc = req_valid & req_ready;
        if (fifo_full) chk("wr_en_while_full", int'(fifo_wr_en), 0);
        if (fifo_wr_en) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: got data 0x%0h grant %0d, expected no write", fifo_wr_data, grant_id);
            end else begin
                e = sb.pop_front();
                chk("wr_data", int'(fifo_wr_data), e & 'hFFFF);
                chk("wr_grant", int'(grant_id), e >> 16);
                chk("ready_on_write", int'(req_ready[grant_id]), 1);
            end
            log_cyc.push_back(cyc);
            log_gid.push_back(int'(grant_id));
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        fifo_full = 1'b0;
        hold = '0;
        for (int i = 0; i < NREQ; i++) rq[i].delete();
        sb.delete();
        @(negedge clk); #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_wr_en", int'(fifo_wr_en), 0);
        chk("rst_ready", int'(req_ready), 0);
        chk("rst_grant", int'(grant_id), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        log_cyc.delete();
        log_gid.delete();
    endtask

    task automatic wait_log(input int n, input string name);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk); #1;
            if (log_gid.size() >= n) return;
        end
        chk({name, "_timeout"}, log_gid.size(), n);
    endtask

    task automatic wait_done(input string name);
        bit empty;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk); #1;
            empty = 1'b1;
            for (int i = 0; i < NREQ; i++) if (rq[i].size() != 0) empty = 1'b0;
            if (empty && sb.size() == 0 && !busy) return;
        end
        chk({name, "_timeout_pending"}, sb.size(), 0);
    endtask

    initial begin
        // T1: single requester, 3-beat packet
        do_reset();
        for (int b = 0; b < 3; b++) begin
            exp_push(1, 'hA001 + b);
            add_beat(1, 'hA001 + b, b == 2);
        end
        @(negedge clk); #1;
        chk("t1_idle_busy", int'(busy), 0);
        chk("t1_idle_wr_en", int'(fifo_wr_en), 0);
        @(negedge clk); #1;
        chk("t1_busy", int'(busy), 1);
        chk("t1_grant", int'(grant_id), 1);
        wait_done("t1");
        chk("t1_beats", log_gid.size(), 3);
        chk("t1_consec_a", log_cyc[1] - log_cyc[0], 1);
        chk("t1_consec_b", log_cyc[2] - log_cyc[1], 1);
        chk("t1_grant_holds_idle", int'(grant_id), 1);

        // T2: round-robin over single-beat packets
        do_reset();
        exp_push(0, 'hB000); exp_push(1, 'hB100); exp_push(2, 'hB200);
        exp_push(3, 'hB300); exp_push(0, 'hB001);
        add_beat(0, 'hB000, 1'b1); add_beat(0, 'hB001, 1'b1);
        add_beat(1, 'hB100, 1'b1); add_beat(2, 'hB200, 1'b1); add_beat(3, 'hB300, 1'b1);
        wait_done("t2");
        chk("t2_beats", log_gid.size(), 5);
        for (int k = 1; k < 5; k++) chk("t2_dead_cycle", log_cyc[k] - log_cyc[k-1], 2);

        // T3: 12-beat packet split by MAX_BURST, req 2 served in between
        do_reset();
        for (int b = 0; b < 8; b++) exp_push(0, 'hC000 + b);
        exp_push(2, 'hD200); exp_push(2, 'hD201);
        for (int b = 8; b < 12; b++) exp_push(0, 'hC000 + b);
        for (int b = 0; b < 12; b++) add_beat(0, 'hC000 + b, b == 11);
        add_beat(2, 'hD200, 1'b0); add_beat(2, 'hD201, 1'b1);
        wait_done("t3");
        chk("t3_beats", log_gid.size(), 14);
        chk("t3_switch_gap", log_cyc[8] - log_cyc[7], 2);

        // T4: fifo_full stall for 3 cycles after beat 2; count must not advance
        do_reset();
        for (int b = 0; b < 10; b++) begin
            exp_push(3, 'hE300 + b);
            add_beat(3, 'hE300 + b, b == 9);
        end
        wait_log(2, "t4");
        @(posedge clk); #1;
        fifo_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            chk("t4_full_wr_en", int'(fifo_wr_en), 0);
            chk("t4_full_ready", int'(req_ready), 0);
            chk("t4_full_busy", int'(busy), 1);
        end
        @(posedge clk); #1;
        fifo_full = 1'b0;
        wait_done("t4");
        chk("t4_beats", log_gid.size(), 10);
        chk("t4_resume_gap", log_cyc[2] - log_cyc[1], 4);
        chk("t4_maxburst_gap", log_cyc[8] - log_cyc[7], 2);

        // T5: reset mid-burst after 2 of 5 beats, then reqs 2 and 3 valid
        do_reset();
        for (int b = 0; b < 5; b++) begin
            exp_push(2, 'hF200 + b);
            add_beat(2, 'hF200 + b, b == 4);
        end
        exp_push(3, 'hF300);
        wait_log(2, "t5");
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk); #1;
        chk("t5_rst_busy", int'(busy), 0);
        chk("t5_rst_wr_en", int'(fifo_wr_en), 0);
        chk("t5_rst_ready", int'(req_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        add_beat(3, 'hF300, 1'b1);
        @(negedge clk); #1;
        chk("t5_post_rst_busy", int'(busy), 0);
        @(negedge clk); #1;
        chk("t5_first_grant", int'(grant_id), 2);
        chk("t5_first_busy", int'(busy), 1);
        wait_done("t5");
        chk("t5_beats", log_gid.size(), 6);

        // T6: granted valid drops 4 cycles mid-packet while req 3 waits
        do_reset();
        for (int b = 0; b < 6; b++) begin
            exp_push(1, 'hA100 + b);
            add_beat(1, 'hA100 + b, b == 5);
        end
        exp_push(3, 'hA300);
        add_beat(3, 'hA300, 1'b1);
        wait_log(2, "t6");
        @(posedge clk); #1;
        hold[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            chk("t6_gap_wr_en", int'(fifo_wr_en), 0);
            chk("t6_gap_grant", int'(grant_id), 1);
            chk("t6_gap_busy", int'(busy), 1);
        end
        @(posedge clk); #1;
        hold[1] = 1'b0;
        wait_done("t6");
        chk("t6_beats", log_gid.size(), 7);
        chk("t6_last_grant", log_gid[6], 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
